// File: rtl/input_divider_ctrl.sv
// input_divider_ctrl
//   Sequencer owning the control pins of input_divider. A configuration is
//   accepted over cfg_valid/cfg_ready, then the divider is gated, the new
//   settings are applied after a settle delay, and the enable is restored
//   after a second settle delay. Optional measurement window counts rising
//   edges of div_out.
//
// Optional feature macro: INPUT_DIVIDER_CTRL_MEAS_EN (MEAS state, div_out
//   synchronizer, edge counter). Undefined: div_en_meas and meas_count tie 0.
//
// Ports:
//   clk, rstb            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready  request handshake (ready only in IDLE)
//   cfg_*                requested divider settings
//   div_*                registered divider control pins
//   div_out              divider output (asynchronous to clk)
//   done                 one-cycle pulse at end of sequence
//   meas_count           rising edges of div_out seen in last window
module input_divider_ctrl #(
  parameter int N_SETTLE = 8,
  parameter int N_MEAS   = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [2:0]       cfg_ndiv,
  input  logic             cfg_bypass_div,
  input  logic             cfg_bypass_div2,
  input  logic             cfg_sel_clk_source,
  output logic             div_en,
  output logic [2:0]       div_ndiv,
  output logic             div_bypass_div,
  output logic             div_bypass_div2,
  output logic             div_sel_clk_source,
  output logic             div_en_meas,
  input  logic             div_out,
  output logic             done,
  output logic [CNT_W-1:0] meas_count
);

  // Sequencing counter is sized from the delays themselves so that a narrow
  // edge counter (small CNT_W) still gets the full measurement window.
  localparam int MAX_DLY = (N_SETTLE > N_MEAS) ? N_SETTLE : N_MEAS;
  localparam int TW      = $clog2(MAX_DLY + 1);
  localparam logic [TW-1:0] SETTLE_M1 = TW'(N_SETTLE - 1);
`ifdef INPUT_DIVIDER_CTRL_MEAS_EN
  localparam logic [TW-1:0] MEAS_M1   = TW'(N_MEAS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OFF,
    S_WAIT_ON,
    S_MEAS,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           load_shadow, apply_cfg, restore_en, meas_end;

  logic           sh_en, sh_bypass_div, sh_bypass_div2, sh_sel_clk_source;
  logic [2:0]     sh_ndiv;

  assign cfg_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_shadow = 1'b0;
    apply_cfg   = 1'b0;
    restore_en  = 1'b0;
    meas_end    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          load_shadow = 1'b1;
          cnt_d       = SETTLE_M1;
          state_d     = S_WAIT_OFF;
        end
      end
      S_WAIT_OFF: begin
        if (cnt_q == '0) begin
          apply_cfg = 1'b1;
          cnt_d     = SETTLE_M1;
          state_d   = S_WAIT_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_ON: begin
        if (cnt_q == '0) begin
          restore_en = 1'b1;
`ifdef INPUT_DIVIDER_CTRL_MEAS_EN
          cnt_d   = MEAS_M1;
          state_d = S_MEAS;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MEAS: begin
        if (cnt_q == '0) begin
          meas_end = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sh_en              <= 1'b0;
      sh_ndiv            <= '0;
      sh_bypass_div      <= 1'b0;
      sh_bypass_div2     <= 1'b0;
      sh_sel_clk_source  <= 1'b0;
      div_en             <= 1'b0;
      div_ndiv           <= '0;
      div_bypass_div     <= 1'b1;
      div_bypass_div2    <= 1'b1;
      div_sel_clk_source <= 1'b0;
      done               <= 1'b0;
    end else begin
      done <= (state_d == S_DONE);
      if (load_shadow) begin
        sh_en             <= cfg_en;
        sh_ndiv           <= cfg_ndiv;
        sh_bypass_div     <= cfg_bypass_div;
        sh_bypass_div2    <= cfg_bypass_div2;
        sh_sel_clk_source <= cfg_sel_clk_source;
        div_en            <= 1'b0;
      end
      if (apply_cfg) begin
        div_ndiv           <= sh_ndiv;
        div_bypass_div     <= sh_bypass_div;
        div_bypass_div2    <= sh_bypass_div2;
        div_sel_clk_source <= sh_sel_clk_source;
      end
      if (restore_en) begin
        div_en <= sh_en;
      end
    end
  end

`ifdef INPUT_DIVIDER_CTRL_MEAS_EN
  logic             sync1_q, sync2_q, hist_q;
  logic             edge_rise;
  logic [CNT_W-1:0] ecnt_q, ecnt_inc;

  assign edge_rise = sync2_q & ~hist_q;
  // Saturating increment; also feeds the latch so the last window cycle counts.
  assign ecnt_inc  = (edge_rise && (ecnt_q != '1)) ? ecnt_q + 1'b1 : ecnt_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      ecnt_q      <= '0;
      div_en_meas <= 1'b0;
      meas_count  <= '0;
    end else begin
      sync1_q <= div_out;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (restore_en) begin
        ecnt_q      <= '0;
        div_en_meas <= 1'b1;
      end else if (state_q == S_MEAS) begin
        ecnt_q <= ecnt_inc;
        if (meas_end) begin
          meas_count  <= ecnt_inc;
          div_en_meas <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_div_out;
  assign unused_div_out = div_out;
  assign div_en_meas    = 1'b0;
  assign meas_count     = '0;
`endif

endmodule

// File: tb/tb_input_divider_ctrl.sv
module tb_input_divider_ctrl;

  localparam int NS = 4;
  localparam int NM = 64;
`ifdef INPUT_DIVIDER_CTRL_MEAS_EN
  localparam bit HAS_MEAS = 1'b1;
`else
  localparam bit HAS_MEAS = 1'b0;
`endif
  localparam int T = 2 * NS + (HAS_MEAS ? NM : 0);

  typedef struct packed {
    logic       en;
    logic [2:0] ndiv;
    logic       bd;
    logic       bd2;
    logic       sel;
  } cfg_t;

  localparam cfg_t RST_CFG = '{en: 1'b0, ndiv: 3'd0, bd: 1'b1, bd2: 1'b1, sel: 1'b0};

  logic       clk = 1'b0;
  logic       rstb;
  logic       cfg_valid;
  logic       cfg_ready, cfg_ready2;
  logic       cfg_en;
  logic [2:0] cfg_ndiv;
  logic       cfg_bypass_div, cfg_bypass_div2, cfg_sel_clk_source;
  logic       div_en, div_bypass_div, div_bypass_div2, div_sel_clk_source, div_en_meas;
  logic [2:0] div_ndiv;
  logic       div_en2, div_bypass_div_2, div_bypass_div2_2, div_sel_clk_source2, div_en_meas2;
  logic [2:0] div_ndiv2;
  logic       div_out  = 1'b0;
  logic       div_out2 = 1'b0;
  logic       done, done2;
  logic [7:0] meas_count;
  logic [3:0] meas_count2;

  int half = 4;
  int n_cmp = 0;
  int n_err = 0;
  cfg_t applied;

  always #5 clk = ~clk;

  // div_out: square wave with period 2*half clk cycles, edges off the clk edge.
  always begin
    repeat (half) @(posedge clk);
    #2 div_out = ~div_out;
  end

  always begin
    repeat (2) @(posedge clk);
    #2 div_out2 = ~div_out2;
  end

  input_divider_ctrl #(.N_SETTLE(NS), .N_MEAS(NM), .CNT_W(8)) dut (
    .clk(clk), .rstb(rstb),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_en(cfg_en), .cfg_ndiv(cfg_ndiv),
    .cfg_bypass_div(cfg_bypass_div), .cfg_bypass_div2(cfg_bypass_div2),
    .cfg_sel_clk_source(cfg_sel_clk_source),
    .div_en(div_en), .div_ndiv(div_ndiv),
    .div_bypass_div(div_bypass_div), .div_bypass_div2(div_bypass_div2),
    .div_sel_clk_source(div_sel_clk_source), .div_en_meas(div_en_meas),
    .div_out(div_out), .done(done), .meas_count(meas_count)
  );

  input_divider_ctrl #(.N_SETTLE(NS), .N_MEAS(NM), .CNT_W(4)) dut_sat (
    .clk(clk), .rstb(rstb),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_en(cfg_en), .cfg_ndiv(cfg_ndiv),
    .cfg_bypass_div(cfg_bypass_div), .cfg_bypass_div2(cfg_bypass_div2),
    .cfg_sel_clk_source(cfg_sel_clk_source),
    .div_en(div_en2), .div_ndiv(div_ndiv2),
    .div_bypass_div(div_bypass_div_2), .div_bypass_div2(div_bypass_div2_2),
    .div_sel_clk_source(div_sel_clk_source2), .div_en_meas(div_en_meas2),
    .div_out(div_out2), .done(done2), .meas_count(meas_count2)
  );

  function automatic logic [9:0] obs_vec();
    return {cfg_ready, done, div_en, div_ndiv, div_bypass_div, div_bypass_div2,
            div_sel_clk_source, div_en_meas};
  endfunction

  // Expected pins k cycles after the transfer edge E0 (sampled after edge E0+k).
  function automatic logic [9:0] exp_vec(int k, cfg_t prev, cfg_t cur);
    cfg_t c;
    logic en, em;
    c  = (k >= NS) ? cur : prev;
    en = (k >= 2 * NS) ? cur.en : 1'b0;
    em = HAS_MEAS && (k >= 2 * NS) && (k < 2 * NS + NM);
    return {(k > T), (k == T), en, c.ndiv, c.bd, c.bd2, c.sel, em};
  endfunction

  function automatic logic [9:0] rst_vec();
    return {1'b1, 1'b0, 1'b0, RST_CFG.ndiv, RST_CFG.bd, RST_CFG.bd2, RST_CFG.sel, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    n_cmp++;
    assert (got >= lo && got <= hi)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic drive(input cfg_t c);
    cfg_en             = c.en;
    cfg_ndiv           = c.ndiv;
    cfg_bypass_div     = c.bd;
    cfg_bypass_div2    = c.bd2;
    cfg_sel_clk_source = c.sel;
  endtask

  // Called at a negedge. Requests c, checks every cycle of the sequence and
  // returns at the negedge after cfg_ready comes back. With hold, cfg_valid
  // stays high with nxt data to exercise the ignored-while-busy path.
  task automatic do_seq(input string name, input cfg_t c, input bit hold, input cfg_t nxt);
    int w;
    int lo, hi, p;
    drive(c);
    cfg_valid = 1'b1;
    w = 0;
    while (!cfg_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) begin
      check({name, " xfer_timeout"}, cfg_ready, 1);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) drive(nxt);
    else cfg_valid = 1'b0;
    for (int k = 0; k <= T + 1; k++) begin
      @(negedge clk);
      check($sformatf("%s k=%0d pins", name, k), obs_vec(), exp_vec(k, applied, c));
      if (k == T) begin
        if (HAS_MEAS) begin
          p  = 2 * half;
          lo = NM / p - 1;
          hi = (NM + p - 1) / p + 1;
          check_range({name, " meas_count"}, meas_count, lo, hi);
          check({name, " meas_count_sat"}, meas_count2, 15);
        end else begin
          check({name, " meas_count"}, meas_count, 0);
          check({name, " meas_count_sat"}, meas_count2, 0);
        end
      end
    end
    applied = c;
  endtask

  task automatic set_period(input int h);
    half = h;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t a, b, c, r;
    logic [6:0] rnd;
    rstb      = 1'b0;
    cfg_valid = 1'b0;
    drive(7'd0);
    applied = RST_CFG;
    repeat (3) @(negedge clk);
    rstb = 1'b1;

    // Idle after reset: pins hold reset values
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("reset idle %0d pins", i), obs_vec(), rst_vec());
      check($sformatf("reset idle %0d meas", i), meas_count, 0);
    end

    // Directed: ndiv=3, bypasses off, enabled; div_out period 8
    a = '{en: 1'b1, ndiv: 3'd3, bd: 1'b0, bd2: 1'b0, sel: 1'b0};
    do_seq("directed", a, 1'b0, a);

    // Request held through the busy sequence with different data afterwards
    b = '{en: 1'b1, ndiv: 3'd5, bd: 1'b0, bd2: 1'b1, sel: 1'b1};
    c = '{en: 1'b1, ndiv: 3'd6, bd: 1'b1, bd2: 1'b0, sel: 1'b0};
    do_seq("held_first", b, 1'b1, c);
    do_seq("held_second", c, 1'b0, c);

    // Identical config back-to-back
    do_seq("repeat", c, 1'b0, c);

    // Disabled divider still runs the full sequence
    r = '{en: 1'b0, ndiv: 3'd2, bd: 1'b0, bd2: 1'b0, sel: 1'b1};
    do_seq("en_off", r, 1'b0, r);

    // Randomized configs and div_out periods
    for (int i = 0; i < 6; i++) begin
      rnd = 7'($urandom);
      r   = rnd;
      set_period(int'($urandom_range(2, 8)));
      do_seq($sformatf("rand%0d", i), r, 1'b0, r);
    end

    // Asynchronous reset in the middle of WAIT_ON
    a = '{en: 1'b1, ndiv: 3'd7, bd: 1'b0, bd2: 1'b0, sel: 1'b1};
    drive(a);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (NS + 2) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    check("async_reset pins", obs_vec(), rst_vec());
    check("async_reset meas", meas_count, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    applied = RST_CFG;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post_reset %0d pins", i), obs_vec(), rst_vec());
    end

    // Recovery after reset
    do_seq("recover", a, 1'b0, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
